piece_decoder: RTL and testbench
================================

PIECE_DECODER -- requirements
Module: piece_decoder

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 resetn  input  1  asynchronous, active-low reset; asserting it clears all state immediately, release is synchronous to clk.
REQ-003 in_valid  input  1  a cell coordinate is offered this cycle.
REQ-004 in_ready  output  1  decoder accepts a cell this cycle; a beat transfers when in_valid && in_ready.
REQ-005 in_x  input  4  cell column.
REQ-006 in_y  input  5  cell row.
REQ-007 out_valid  output  1  decoded result is held on out_type, out_x, out_y and out_err.
REQ-008 out_ready  input  1  consumer takes the result; the result transfers when out_valid && out_ready.
REQ-009 out_type  output  3  piece code: O=0, I=1, L=2, J=3, S=4, Z=5, T=6, 7 on error.
REQ-010 out_x  output  4  central-block column; 0 on error.
REQ-011 out_y  output  5  central-block row; 0 on error.
REQ-012 out_err  output  1  the four cells match no spawn-orientation piece.

Function
REQ-013 The decoder SHALL be the inverse of the piece-to-cells mapping: it takes four cells of one piece and returns the piece type and central block.
REQ-014 State machine: COLLECT → MATCH → HOLD → COLLECT.
  - COLLECT: in_ready=1; beat counter counts 0..3; the 4th transferred beat moves to MATCH.
  - MATCH: exactly 1 cycle; in_ready=0.
  - HOLD: out_valid=1; in_ready=0; out_valid && out_ready moves to COLLECT.
REQ-015 Cells SHALL be accepted in any order; the result SHALL NOT depend on beat order.
REQ-016 In MATCH: minx and miny are the minima over the four cells; for each cell, dx=x-minx (4 bits) and dy=y-miny (5 bits).
REQ-017 Any cell with dx>3 or dy>1 SHALL force an error.
REQ-018 Build an 8-bit mask by setting bit (dy*4+dx) for each cell.
REQ-019 Mask match table: O=0x33, I=0x0F, L=0x47, J=0x17, S=0x63, Z=0x36, T=0x27. Any other mask SHALL set out_err=1.
REQ-020 Duplicate cells reduce the popcount below 4, so they SHALL never match and SHALL set out_err=1.
REQ-021 Centre: O gives (minx, miny); all other types give (minx+1, miny).
REQ-022 Arithmetic is raw modulo-width; a piece whose cells wrapped past column 0 or 15 SHALL decode as an error, not be unwrapped.
REQ-023 Latency: the 4th beat transfers in cycle N; out_valid SHALL rise in cycle N+2.
REQ-024 Outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 A result handshake in cycle M SHALL set in_ready=1 in cycle M+1; there is no same-cycle turnaround.
REQ-026 in_x and in_y SHALL be ignored when no beat transfers.

Reset
REQ-027 resetn=0 SHALL force COLLECT, beat count 0, in_ready=1 after release, out_valid=0, out_type=0, out_x=0, out_y=0, out_err=0.
REQ-028 Reset mid-collection or mid-HOLD SHALL discard all partial beats and any pending result without emitting output.

Configuration
REQ-029 Macro PIECE_DECODER_ERRCNT_EN, when defined, SHALL add output err_count[7:0].
  - It increments once per transferred result with out_err=1 and saturates at 255.
  - It resets to 0.
REQ-030 When PIECE_DECODER_ERRCNT_EN is undefined, err_count SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 T piece: beats (5,10),(5,11),(4,10),(6,10) → out_type=6, out_x=5, out_y=10, out_err=0; out_valid rises 2 cycles after the last beat.
REQ-032 O piece in shuffled order: beats (1,1),(0,0),(1,0),(0,1) → out_type=0, out_x=0, out_y=0.
REQ-033 Error case: beats (3,3),(3,3),(4,3),(5,3) → out_err=1, out_type=7, out_x=0, out_y=0; err_count=1 when the macro is defined.
REQ-034 Backpressure: I piece (2,7),(3,7),(4,7),(5,7) with out_ready=0 for 3 cycles → out_type=1, out_x=3, out_y=7 held stable and in_ready=0 throughout; in_ready=1 the cycle after the handshake.
REQ-035 Reset mid-collection: 2 beats, pulse resetn low, then S piece (3,4),(4,4),(4,5),(5,5) → out_type=4, out_x=4, out_y=4; no output from the discarded beats.
REQ-036 Wrap case: I cells (15,0),(0,0),(1,0),(2,0) → out_err=1.

Source files
------------

// File: rtl/piece_decoder.sv
//------------------------------------------------------------------------------
// Module   : piece_decoder
// Purpose  : Collects four cells of one falling-block piece and returns the
//            piece type and its central block, or an error for invalid shapes.
// Options  : PIECE_DECODER_ERRCNT_EN adds a saturating err_count output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module piece_decoder (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_x,
  input  logic [4:0] in_y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_type,
  output logic [3:0] out_x,
  output logic [4:0] out_y,
  output logic       out_err
`ifdef PIECE_DECODER_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam logic [7:0] c_MASK_O = 8'h33;
  localparam logic [7:0] c_MASK_I = 8'h0F;
  localparam logic [7:0] c_MASK_L = 8'h47;
  localparam logic [7:0] c_MASK_J = 8'h17;
  localparam logic [7:0] c_MASK_S = 8'h63;
  localparam logic [7:0] c_MASK_Z = 8'h36;
  localparam logic [7:0] c_MASK_T = 8'h27;

  localparam logic [2:0] c_TYPE_O   = 3'd0;
  localparam logic [2:0] c_TYPE_I   = 3'd1;
  localparam logic [2:0] c_TYPE_L   = 3'd2;
  localparam logic [2:0] c_TYPE_J   = 3'd3;
  localparam logic [2:0] c_TYPE_S   = 3'd4;
  localparam logic [2:0] c_TYPE_Z   = 3'd5;
  localparam logic [2:0] c_TYPE_T   = 3'd6;
  localparam logic [2:0] c_TYPE_ERR = 3'd7;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_MATCH   = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_cnt;
  logic [3:0] r_x [4];
  logic [4:0] r_y [4];
  logic       r_in_ready;
  logic       r_out_valid;
  logic [2:0] r_out_type;
  logic [3:0] r_out_x;
  logic [4:0] r_out_y;
  logic       r_out_err;

  logic [3:0] w_minx;
  logic [4:0] w_miny;
  logic [3:0] w_dx [4];
  logic [4:0] w_dy [4];
  logic [7:0] w_mask;
  logic       w_range_err;
  logic       w_match;
  logic [2:0] w_type;
  logic       w_err;
  logic [3:0] w_cx;

  always_comb begin
    w_minx = r_x[0];
    w_miny = r_y[0];
    for (int i = 1; i < 4; i++) begin
      if (r_x[i] < w_minx) w_minx = r_x[i];
      if (r_y[i] < w_miny) w_miny = r_y[i];
    end
  end

  // Offsets are modulo-width, so wrapped cells land far from the minimum.
  always_comb begin
    w_mask      = 8'h00;
    w_range_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_dx[i] = r_x[i] - w_minx;
      w_dy[i] = r_y[i] - w_miny;
      if (w_dx[i] > 4'd3 || w_dy[i] > 5'd1) begin
        w_range_err = 1'b1;
      end else begin
        w_mask[{w_dy[i][0], w_dx[i][1:0]}] = 1'b1;
      end
    end
  end

  always_comb begin
    w_type  = c_TYPE_ERR;
    w_match = 1'b1;
    case (w_mask)
      c_MASK_O: w_type = c_TYPE_O;
      c_MASK_I: w_type = c_TYPE_I;
      c_MASK_L: w_type = c_TYPE_L;
      c_MASK_J: w_type = c_TYPE_J;
      c_MASK_S: w_type = c_TYPE_S;
      c_MASK_Z: w_type = c_TYPE_Z;
      c_MASK_T: w_type = c_TYPE_T;
      default:  w_match = 1'b0;
    endcase
    w_err = w_range_err || !w_match;
    w_cx  = (w_type == c_TYPE_O) ? w_minx : w_minx + 4'd1;
  end

`ifdef PIECE_DECODER_ERRCNT_EN
  logic [7:0] r_err_count;
  assign err_count = r_err_count;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_COLLECT;
      r_cnt       <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_type  <= 3'd0;
      r_out_x     <= 4'd0;
      r_out_y     <= 5'd0;
      r_out_err   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_x[i] <= 4'd0;
        r_y[i] <= 5'd0;
      end
`ifdef PIECE_DECODER_ERRCNT_EN
      r_err_count <= 8'd0;
`endif
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (in_valid && r_in_ready) begin
            r_x[r_cnt] <= in_x;
            r_y[r_cnt] <= in_y;
            r_cnt      <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state    <= ST_MATCH;
              r_in_ready <= 1'b0;
            end
          end
        end
        ST_MATCH: begin
          r_out_valid <= 1'b1;
          r_out_err   <= w_err;
          r_out_type  <= w_err ? c_TYPE_ERR : w_type;
          r_out_x     <= w_err ? 4'd0 : w_cx;
          r_out_y     <= w_err ? 5'd0 : w_miny;
          r_state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_COLLECT;
`ifdef PIECE_DECODER_ERRCNT_EN
            if (r_out_err && r_err_count != 8'hFF) begin
              r_err_count <= r_err_count + 8'd1;
            end
`endif
          end
        end
        default: begin
          r_state     <= ST_COLLECT;
          r_cnt       <= 2'd0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_type  = r_out_type;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign out_err   = r_out_err;

endmodule

`default_nettype wire

// File: tb/tb_piece_decoder.sv
//------------------------------------------------------------------------------
// Module   : tb_piece_decoder
// Purpose  : Scoreboard bench for piece_decoder with a shape-search reference.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_piece_decoder;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_x;
  logic [4:0] in_y;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_type;
  logic [3:0] out_x;
  logic [4:0] out_y;
  logic       out_err;
`ifdef PIECE_DECODER_ERRCNT_EN
  logic [7:0] err_count;
`endif

  always #5 clk = ~clk;

  piece_decoder dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_type  (out_type),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_err   (out_err)
`ifdef PIECE_DECODER_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  typedef struct {
    int t;
    int x;
    int y;
    int e;
  } exp_t;

  exp_t sb[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   ready_mode = 0;
  int   model_ec   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Spawn shapes as cell offsets from the central block.
  function automatic void piece_off(input int t, output int ox[4], output int oy[4]);
    case (t)
      0:       begin ox = '{0, 1, 0, 1};   oy = '{0, 0, 1, 1}; end
      1:       begin ox = '{-1, 0, 1, 2};  oy = '{0, 0, 0, 0}; end
      2:       begin ox = '{-1, 0, 1, 1};  oy = '{0, 0, 0, 1}; end
      3:       begin ox = '{-1, 0, 1, -1}; oy = '{0, 0, 0, 1}; end
      4:       begin ox = '{-1, 0, 0, 1};  oy = '{0, 0, 1, 1}; end
      5:       begin ox = '{0, 1, -1, 0};  oy = '{0, 0, 1, 1}; end
      default: begin ox = '{-1, 0, 1, 0};  oy = '{0, 0, 0, 1}; end
    endcase
  endfunction

  // Try every piece at every on-board centre; a match needs all four of its
  // cells present among the inputs, which also rules out duplicates.
  function automatic exp_t model(input int xs[4], input int ys[4]);
    exp_t r;
    int ox[4];
    int oy[4];
    r = '{7, 0, 0, 1};
    for (int t = 0; t < 7; t++) begin
      piece_off(t, ox, oy);
      for (int cx = 0; cx < 16; cx++) begin
        for (int cy = 0; cy < 32; cy++) begin
          bit ok = 1'b1;
          for (int k = 0; k < 4; k++) begin
            int  px = cx + ox[k];
            int  py = cy + oy[k];
            bit  found = 1'b0;
            if (px < 0 || px > 15 || py < 0 || py > 31) ok = 1'b0;
            for (int j = 0; j < 4; j++)
              if (xs[j] == px && ys[j] == py) found = 1'b1;
            if (!found) ok = 1'b0;
          end
          if (ok) r = '{t, cx, cy, 0};
        end
      end
    end
    return r;
  endfunction

  task automatic send_beat(input int x, input int y);
    int gap = $urandom_range(0, 2);
    int waited = 0;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_x     = 4'($urandom);
      in_y     = 5'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_x     = 4'(x);
    in_y     = 5'(y);
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      waited++;
      if (waited > 100) begin
        chk("in_ready_timeout", int'(in_ready), 1);
        break;
      end
    end
    in_valid = 1'b0;
    in_x     = 4'($urandom);
    in_y     = 5'($urandom);
  endtask

  task automatic issue(input int xs[4], input int ys[4], input exp_t e);
    sb.push_back(e);
    for (int k = 0; k < 4; k++) send_beat(xs[k], ys[k]);
  endtask

  task automatic directed(input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2, input int x3, input int y3,
                          input int t, input int ex, input int ey, input int err);
    int   xs[4];
    int   ys[4];
    exp_t e;
    xs = '{x0, x1, x2, x3};
    ys = '{y0, y1, y2, y3};
    e  = '{t, ex, ey, err};
    issue(xs, ys, e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_ready();
    int hold = 0;
    forever begin
      @(posedge clk); #1;
      if (out_valid) hold++;
      else hold = 0;
      case (ready_mode)
        0:       out_ready = ($urandom_range(0, 2) != 0);
        1:       out_ready = (hold > 3);
        default: out_ready = 1'b0;
      endcase
    end
  endtask

  task automatic run_monitor();
    int   mbeats = 0;
    int   lat = 0;
    bit   lat_on = 1'b0;
    bit   prev_hold = 1'b0;
    bit   hs_prev = 1'b0;
    bit   rel = 1'b0;
    exp_t e;
`ifdef PIECE_DECODER_ERRCNT_EN
    bit   ec_pend = 1'b0;
`endif
    forever begin
      @(negedge clk);
      if (!resetn) begin
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_type", int'(out_type), 0);
        chk("rst_out_x", int'(out_x), 0);
        chk("rst_out_y", int'(out_y), 0);
        chk("rst_out_err", int'(out_err), 0);
`ifdef PIECE_DECODER_ERRCNT_EN
        chk("rst_err_count", int'(err_count), 0);
        ec_pend  = 1'b0;
        model_ec = 0;
`endif
        mbeats = 0; lat_on = 1'b0; prev_hold = 1'b0; hs_prev = 1'b0; rel = 1'b1;
      end else begin
        if (rel) begin
          chk("in_ready_after_reset", int'(in_ready), 1);
          rel = 1'b0;
        end
        if (hs_prev) chk("in_ready_after_handshake", int'(in_ready), 1);
`ifdef PIECE_DECODER_ERRCNT_EN
        if (ec_pend) chk("err_count", int'(err_count), model_ec);
        ec_pend = 1'b0;
`endif
        if (prev_hold) chk("valid_held", int'(out_valid), 1);
        if (lat_on) begin
          lat++;
          if (lat == 1) chk("latency_n1", int'(out_valid), 0);
          else begin
            chk("latency_n2", int'(out_valid), 1);
            lat_on = 1'b0;
          end
        end
        if (in_valid && in_ready) begin
          mbeats++;
          if (mbeats == 4) begin
            mbeats = 0; lat_on = 1'b1; lat = 0;
          end
        end
        if (out_valid) begin
          chk("in_ready_in_hold", int'(in_ready), 0);
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: out_valid=1 type=%0d with no result expected", out_type);
          end else begin
            e = sb[0];
            chk("out_type", int'(out_type), e.t);
            chk("out_x", int'(out_x), e.x);
            chk("out_y", int'(out_y), e.y);
            chk("out_err", int'(out_err), e.e);
            if (out_ready) begin
              void'(sb.pop_front());
`ifdef PIECE_DECODER_ERRCNT_EN
              if (e.e != 0 && model_ec < 255) model_ec++;
              ec_pend = 1'b1;
`endif
            end
          end
        end
        prev_hold = out_valid && !out_ready;
        hs_prev   = out_valid && out_ready;
      end
    end
  endtask

  initial begin
    int xs[4];
    int ys[4];
    int n;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_x      = 4'd0;
    in_y      = 5'd0;
    out_ready = 1'b0;
    fork
      run_monitor();
      run_ready();
    join_none
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    directed(5, 10, 5, 11, 4, 10, 6, 10,  6, 5, 10, 0);
    wait_idle();
    directed(1, 1, 0, 0, 1, 0, 0, 1,      0, 0, 0, 0);
    wait_idle();
    directed(3, 3, 3, 3, 4, 3, 5, 3,      7, 0, 0, 1);
    wait_idle();
    ready_mode = 1;
    directed(2, 7, 3, 7, 4, 7, 5, 7,      1, 3, 7, 0);
    wait_idle();
    ready_mode = 0;

    send_beat(0, 0);
    send_beat(1, 0);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    directed(3, 4, 4, 4, 4, 5, 5, 5,      4, 4, 4, 0);
    wait_idle();
    directed(15, 0, 0, 0, 1, 0, 2, 0,     7, 0, 0, 1);
    wait_idle();

    // Drop a pending result by resetting while it is held.
    ready_mode = 2;
    directed(0, 0, 1, 0, 2, 0, 3, 0,      1, 1, 0, 0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    resetn = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    ready_mode = 0;

    for (int txn = 0; txn < 150; txn++) begin
      int mode = $urandom_range(0, 3);
      if (mode <= 1) begin
        int ox[4];
        int oy[4];
        int cx = $urandom_range(0, 15);
        int cy = $urandom_range(0, 31);
        piece_off($urandom_range(0, 6), ox, oy);
        for (int k = 0; k < 4; k++) begin
          xs[k] = (cx + ox[k]) & 15;
          ys[k] = (cy + oy[k]) & 31;
        end
      end else if (mode == 2) begin
        int bx = $urandom_range(0, 15);
        int by = $urandom_range(0, 31);
        for (int k = 0; k < 4; k++) begin
          xs[k] = (bx + $urandom_range(0, 3)) & 15;
          ys[k] = (by + $urandom_range(0, 1)) & 31;
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          xs[k] = $urandom_range(0, 15);
          ys[k] = $urandom_range(0, 31);
        end
      end
      for (int k = 3; k > 0; k--) begin
        int j = $urandom_range(0, k);
        int tx = xs[k];
        int ty = ys[k];
        xs[k] = xs[j]; ys[k] = ys[j];
        xs[j] = tx;    ys[j] = ty;
      end
      issue(xs, ys, model(xs, ys));
    end
    wait_idle();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
